// File: rtl/aes_req_arb_pkg.sv
// Shared types and constants for the AES request arbiter.
package aes_req_arb_pkg;

  // Session sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Width of the per-session block counter.
  localparam int BLKCNT_W = 16;

  // Saturating increment for the block counter: sticks at all-ones.
  function automatic logic [BLKCNT_W-1:0] sat_inc(input logic [BLKCNT_W-1:0] v);
    return (v == {BLKCNT_W{1'b1}}) ? v : v + BLKCNT_W'(1);
  endfunction

endpackage

// File: rtl/aes_req_arb_if.sv
// Requester-side and core-side signals of the AES arbiter bundled together.
// The arbiter uses the slave view; a driver of requests/core responses uses master.
interface aes_req_arb_if
  import aes_req_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) ();

  // Requester side.
  logic [NREQ-1:0]     iReq;
  logic [NREQ-1:0]     iCont;
  // Core side.
  logic                iCoreReady;
  logic                iCoreValid;
  logic                iCoreEnd;
  // Arbiter outputs.
  logic                oCoreStart;
  logic                oCoreCont;
  logic [NREQ-1:0]     oGnt;
  logic [IDW-1:0]      oKeySel;
  logic [NREQ-1:0]     oValid;
  logic [NREQ-1:0]     oDone;
  logic [NREQ-1:0]     oTrunc;
  logic [BLKCNT_W-1:0] oBlkCnt;

  modport slave (
    input  iReq, iCont, iCoreReady, iCoreValid, iCoreEnd,
    output oCoreStart, oCoreCont, oGnt, oKeySel, oValid, oDone, oTrunc, oBlkCnt
  );

  modport master (
    output iReq, iCont, iCoreReady, iCoreValid, iCoreEnd,
    input  oCoreStart, oCoreCont, oGnt, oKeySel, oValid, oDone, oTrunc, oBlkCnt
  );

endinterface

// File: rtl/aes_req_arb_rr_pick.sv
// Combinational round-robin picker. Searches ptr+1, ptr+2, ... (mod NREQ)
// for the first set request by rotating a doubled request vector so the
// search start lands at bit 0, then priority-encoding the lowest set bit.
module aes_req_arb_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  int                base;
  int                off;

  // Doubling the vector lets a plain part-select act as a rotate.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_dbl
    assign dbl[gi]        = req_i[gi];
    assign dbl[gi + NREQ] = req_i[gi];
  end

  // Rotate to the search start, find the lowest set bit, map back to an index.
  always_comb begin
    base  = (int'(ptr_i) + 1) % NREQ;
    rot   = dbl[base +: NREQ];
    off   = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) off = k;
    end
    any_o = |req_i;
    idx_o = IDW'((base + off) % NREQ);
    gnt_o = '0;
    if (any_o) gnt_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/aes_req_arb.sv
// Round-robin session arbiter in front of one AES-128 core.
// A requester owns the core (and the key mux) for a whole multi-block
// message; the core start/continue handshake, per-block valid and the
// session-done pulse are routed to the current owner only.
module aes_req_arb
  import aes_req_arb_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int IDW    = $clog2(NREQ),
  parameter int MAXBLK = 0            // max blocks per grant, 0 = unlimited
) (
  input logic           iClk,
  input logic           iRst,
  aes_req_arb_if.slave  bus
);

  state_e              state_q, state_d;
  logic [IDW-1:0]      ptr_q, ptr_d;        // last owner, round-robin origin
  logic [IDW-1:0]      owner_q, owner_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [BLKCNT_W-1:0] cnt_q, cnt_d;
  logic                trunc_q, trunc_d;

  logic [NREQ-1:0]     pick_gnt;
  logic [IDW-1:0]      pick_idx;
  logic                pick_any;
  logic                lim;

  aes_req_arb_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req_i (bus.iReq),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // The block limit is judged on the registered count so that the block
  // which will hit the limit already sees continue forced low.
  if (MAXBLK == 0) begin : g_nolim
    assign lim = 1'b0;
  end else begin : g_lim
    localparam logic [BLKCNT_W-1:0] LIM_AT = BLKCNT_W'(MAXBLK - 1);
    assign lim = (cnt_q >= LIM_AT);
  end

  // State and session registers; reset abandons any session silently.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= IDLE;
      ptr_q   <= IDW'(NREQ - 1);
      owner_q <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      trunc_q <= trunc_d;
    end
  end

  // Next-state logic: arbitrate in IDLE, pulse start, count blocks until the
  // core ends the session, then report done and move the round-robin origin.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    trunc_d = trunc_q;
    case (state_q)
      IDLE: begin
        if (pick_any && bus.iCoreReady) begin
          gnt_d   = pick_gnt;
          owner_d = pick_idx;
          cnt_d   = '0;
          trunc_d = 1'b0;
          state_d = START;
        end
      end
      START: begin
        state_d = BUSY;
      end
      BUSY: begin
        // Valid and end in the same cycle: count the block, then finish.
        if (bus.iCoreValid) cnt_d = sat_inc(cnt_q);
        if (bus.iCoreEnd) begin
          trunc_d = lim && bus.iCont[owner_q];
          state_d = DONE;
        end
      end
      DONE: begin
        ptr_d   = owner_q;
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output routing; everything pulse-like is gated by the state so core
  // pulses outside a session never reach a requester.
  always_comb begin
    bus.oCoreStart = (state_q == START);
    bus.oCoreCont  = (state_q == BUSY) && bus.iCont[owner_q] && !lim;
    bus.oValid     = ((state_q == BUSY) && bus.iCoreValid) ? gnt_q : '0;
    bus.oDone      = (state_q == DONE) ? gnt_q : '0;
    bus.oTrunc     = ((state_q == DONE) && trunc_q) ? gnt_q : '0;
  end

  assign bus.oGnt    = gnt_q;
  assign bus.oKeySel = owner_q;
  assign bus.oBlkCnt = cnt_q;

endmodule
